// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mandel_pkg
// Brief    : Shared constants, scheduler state encoding and helpers.
// Revision : 1.0
// ============================================================================
package mandel_pkg;

  localparam int Q_FRAC         = 10;
  localparam int DEF_N          = 16;
  localparam int DEF_NC         = 8;
  localparam int DEF_NCORES     = 4;
  localparam int DEF_BLOCK_SIZE = 64;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2
  } sched_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mandel_coord_gen.sv
`default_nettype none
// ============================================================================
// Module   : mandel_coord_gen
// Brief    : Raster x/y counters and sign-preserving c_real/c_imag stepping.
// Revision : 1.0
// ============================================================================
module mandel_coord_gen
  import mandel_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [N-1:0] c_real_init_i,
  input  logic [N-1:0] c_imag_init_i,
  input  logic [N-1:0] c_step_i,
  output logic         last_pixel_o,
  output logic [N-1:0] c_real_o,
  output logic [N-1:0] c_imag_o
);
  localparam int            XW        = ptr_width(BLOCK_SIZE);
  localparam logic [XW-1:0] EDGE_LAST = XW'(BLOCK_SIZE - 1);

  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic [N-1:0]  re_q, re_d, im_q, im_d, re0_q, re0_d;
  logic [N-2:0]  step_q, step_d;
  logic          w_unused_step_sign;

  // The step is magnitude-only; the coordinate sign bit never changes.
  function automatic logic [N-1:0] step_keep_sign(input logic [N-1:0] v, input logic [N-2:0] s);
    return {v[N-1], v[N-2:0] + s};
  endfunction

  assign w_unused_step_sign = c_step_i[N-1];

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    re_d   = re_q;
    im_d   = im_q;
    re0_d  = re0_q;
    step_d = step_q;
    if (load_i) begin
      x_d    = '0;
      y_d    = '0;
      re_d   = c_real_init_i;
      im_d   = c_imag_init_i;
      re0_d  = c_real_init_i;
      step_d = c_step_i[N-2:0];
    end else if (advance_i) begin
      if (x_q == EDGE_LAST) begin
        x_d  = '0;
        y_d  = y_q + 1'b1;
        re_d = re0_q;
        im_d = step_keep_sign(im_q, step_q);
      end else begin
        x_d  = x_q + 1'b1;
        re_d = step_keep_sign(re_q, step_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      re_q   <= '0;
      im_q   <= '0;
      re0_q  <= '0;
      step_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      re_q   <= re_d;
      im_q   <= im_d;
      re0_q  <= re0_d;
      step_q <= step_d;
    end
  end

  assign last_pixel_o = (x_q == EDGE_LAST) && (y_q == EDGE_LAST);
  assign c_real_o     = re_q;
  assign c_imag_o     = im_q;

endmodule
`default_nettype wire

// File: rtl/mandel_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mandel_core_scheduler
// Brief    : Round-robin tile dispatch to NCORES engines, raster-order collect.
//            Define MANDEL_SCHED_ABORT_EN to add the abort_i port.
// Revision : 1.0
// ============================================================================
module mandel_core_scheduler
  import mandel_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int NC         = DEF_NC,
  parameter int NCORES     = DEF_NCORES,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [N-1:0]         c_real_init_i,
  input  logic [N-1:0]         c_imag_init_i,
  input  logic [N-1:0]         c_step_i,
  output logic [NCORES*N-1:0]  core_c_real_o,
  output logic [NCORES*N-1:0]  core_c_imag_o,
  output logic [NCORES-1:0]    core_run_o,
  input  logic [NCORES-1:0]    core_done_i,
  input  logic [NCORES*NC-1:0] core_count_i,
  output logic                 out_valid_o,
  output logic [NC-1:0]        out_data_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
`ifdef MANDEL_SCHED_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic                 tile_done_o
);
  localparam int            PW       = ptr_width(NCORES);
  localparam int            CW       = 2 * ptr_width(BLOCK_SIZE);
  localparam logic [PW-1:0] PTR_LAST = PW'(NCORES - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(BLOCK_SIZE * BLOCK_SIZE - 1);

  sched_state_e             state_q, state_d;
  logic [NCORES-1:0]        pend_q, pend_d, mask_q;
  logic [PW-1:0]            dptr_q, dptr_d, cptr_q, cptr_d;
  logic [CW-1:0]            ocnt_q, ocnt_d;
  logic [NCORES-1:0][N-1:0] hold_re_q, hold_im_q;
  logic [NCORES-1:0]        w_done_ok;
  logic [N-1:0]             w_c_real, w_c_imag;
  logic                     w_abort, w_busy, w_load, w_issue, w_xfer, w_last_pixel;

`ifdef MANDEL_SCHED_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  assign w_busy  = (state_q != S_IDLE);
  assign w_load  = (state_q == S_IDLE) && start_i && !w_abort;
  assign w_issue = (state_q == S_DISPATCH) && !pend_q[dptr_q] && !w_abort;
  assign w_xfer  = out_valid_o && out_ready_i;

  mandel_coord_gen #(
    .N          (N),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_coord (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (w_load),
    .advance_i     (w_issue),
    .c_real_init_i (c_real_init_i),
    .c_imag_init_i (c_imag_init_i),
    .c_step_i      (c_step_i),
    .last_pixel_o  (w_last_pixel),
    .c_real_o      (w_c_real),
    .c_imag_o      (w_c_imag)
  );

  // A core's done level is stale on its run cycle and the one after.
  for (genvar i = 0; i < NCORES; i++) begin : g_core
    assign core_run_o[i]            = w_issue && (dptr_q == PW'(i));
    assign w_done_ok[i]             = core_done_i[i] && !core_run_o[i] && !mask_q[i];
    assign core_c_real_o[i*N +: N]  = core_run_o[i] ? w_c_real : hold_re_q[i];
    assign core_c_imag_o[i*N +: N]  = core_run_o[i] ? w_c_imag : hold_im_q[i];
  end

  assign out_valid_o = w_busy && pend_q[cptr_q] && w_done_ok[cptr_q] && !w_abort;
  assign busy_o      = w_busy;
  assign tile_done_o = (state_q == S_DRAIN) && w_xfer && (ocnt_q == PIX_LAST);

  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (w_busy && (cptr_q == PW'(i))) out_data_o = core_count_i[i*NC +: NC];
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dptr_d  = dptr_q;
    cptr_d  = cptr_q;
    ocnt_d  = ocnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_DISPATCH;
          pend_d  = '0;
          dptr_d  = '0;
          cptr_d  = '0;
          ocnt_d  = '0;
        end
      end
      S_DISPATCH: if (w_issue && w_last_pixel) state_d = S_DRAIN;
      S_DRAIN:    if (tile_done_o) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (w_issue) begin
      pend_d[dptr_q] = 1'b1;
      dptr_d         = (dptr_q == PTR_LAST) ? '0 : dptr_q + 1'b1;
    end
    if (w_xfer) begin
      pend_d[cptr_q] = 1'b0;
      cptr_d         = (cptr_q == PTR_LAST) ? '0 : cptr_q + 1'b1;
      ocnt_d         = ocnt_q + 1'b1;
    end
    if (w_abort) begin
      state_d = S_IDLE;
      pend_d  = '0;
      dptr_d  = '0;
      cptr_d  = '0;
      ocnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      dptr_q    <= '0;
      cptr_q    <= '0;
      ocnt_q    <= '0;
      hold_re_q <= '0;
      hold_im_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= core_run_o;
      dptr_q  <= dptr_d;
      cptr_q  <= cptr_d;
      ocnt_q  <= ocnt_d;
      for (int i = 0; i < NCORES; i++) begin
        if (core_run_o[i]) begin
          hold_re_q[i] <= w_c_real;
          hold_im_q[i] <= w_c_imag;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mandel_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandel_core_scheduler
// Brief    : Self-checking bench: 4 cores, 4x4 tile, modelled engines.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mandel_core_scheduler;
  localparam int N = 16, NC = 8, NCORES = 4, BS = 4, PIX = BS * BS;

  logic                 clk = 1'b0;
  logic                 rst, start, out_ready;
  logic [N-1:0]         cri, cii, cst;
  logic [NCORES*N-1:0]  core_cr, core_ci;
  logic [NCORES-1:0]    core_run;
  logic [NCORES-1:0]    core_done = '0;
  logic [NCORES*NC-1:0] core_count;
  logic [NCORES-1:0][NC-1:0] mcnt = '0;
  logic                 out_valid, busy, tile_done;
  logic [NC-1:0]        out_data;
`ifdef MANDEL_SCHED_ABORT_EN
  logic                 abort;
`endif

  always #5 clk = ~clk;
  assign core_count = mcnt;

  mandel_core_scheduler #(.N(N), .NC(NC), .NCORES(NCORES), .BLOCK_SIZE(BS)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .c_real_init_i (cri),
    .c_imag_init_i (cii),
    .c_step_i      (cst),
    .core_c_real_o (core_cr),
    .core_c_imag_o (core_ci),
    .core_run_o    (core_run),
    .core_done_i   (core_done),
    .core_count_i  (core_count),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_ready_i   (out_ready),
    .busy_o        (busy),
`ifdef MANDEL_SCHED_ABORT_EN
    .abort_i       (abort),
`endif
    .tile_done_o   (tile_done)
  );

  function automatic logic [NC-1:0] fpix(input logic [N-1:0] r, input logic [N-1:0] im);
    return r[7:0] ^ im[11:4] ^ r[15:8];
  endfunction

  function automatic logic [N-1:0] stepc(input logic [N-1:0] v, input logic [N-1:0] s);
    return {v[N-1], v[N-2:0] + s[N-2:0]};
  endfunction

  // Engine model: done stays high through the run cycle and the next, then
  // drops, and rises lat cycles after run with the pixel's count.
  int          lat [NCORES];
  int          tmr [NCORES] = '{default: 0};
  logic [N-1:0] mcr [NCORES];
  logic [N-1:0] mci [NCORES];

  always @(posedge clk) begin
    for (int i = 0; i < NCORES; i++) begin
      if (core_run[i]) begin
        tmr[i] <= lat[i];
        mcr[i] <= core_cr[i*N +: N];
        mci[i] <= core_ci[i*N +: N];
      end else if (tmr[i] != 0) begin
        tmr[i] <= tmr[i] - 1;
        if (tmr[i] == lat[i]) core_done[i] <= 1'b0;
        if (tmr[i] == 1) begin
          core_done[i] <= 1'b1;
          mcnt[i]      <= fpix(mcr[i], mci[i]);
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0] cr, ci, st;
    bit           ooo;
    int           stall_at;
    bit           drain_start;
    int           exp_outs;
    int           exp_tdone;
  } tile_t;

  typedef struct packed { logic [N-1:0] r; logic [N-1:0] i; } crd_t;

  tile_t        tiles [4];
  crd_t         crd_q [$];
  logic [NC-1:0] exp_q [$];
  logic [N-1:0] iss_r [PIX];
  logic [N-1:0] iss_i [PIX];
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_tile(input tile_t t, input string tag);
    logic [N-1:0]  r, im, held;
    logic [NC-1:0] e;
    crd_t          c;
    int outs = 0, runs = 0, tdn = 0, first_run = -1, stall_left = 0, blk = 0, drain_cnt = 0;
    bit held_ok = 0, stall_bad = 0, busy_after = 0;
    for (int i = 0; i < NCORES; i++) lat[i] = t.ooo ? 40 - 9 * i : 10;
    crd_q.delete();
    exp_q.delete();
    r  = t.cr;
    im = t.ci;
    for (int k = 0; k < PIX; k++) begin
      crd_q.push_back({r, im});
      exp_q.push_back(fpix(r, im));
      if (k % BS == BS - 1) begin
        r  = t.cr;
        im = stepc(im, t.st);
      end else begin
        r = stepc(r, t.st);
      end
    end
    @(negedge clk);
    cri = t.cr; cii = t.ci; cst = t.st; start = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && tdn == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        cri = ~t.cr; cii = ~t.ci; cst = ~t.st;
      end
      for (int i = 0; i < NCORES; i++) begin
        if (core_run[i]) begin
          if (first_run < 0) first_run = cyc;
          if (runs < PIX) begin
            c = crd_q.pop_front();
            iss_r[runs] = core_cr[i*N +: N];
            iss_i[runs] = core_ci[i*N +: N];
            check({tag, "_issue"}, {8'(i), core_cr[i*N +: N], core_ci[i*N +: N]},
                  {8'(runs % NCORES), c.r, c.i});
          end else begin
            check({tag, "_extra_issue"}, runs, PIX - 1);
          end
          runs++;
        end
      end
      if (stall_left > 0) begin
        if (out_valid) begin
          if (!held_ok) begin held = out_data; held_ok = 1; end
          else if (out_data != held) stall_bad = 1;
        end else if (held_ok) stall_bad = 1;
        if (core_run[blk]) stall_bad = 1;
        stall_left--;
        if (stall_left == 0) begin
          out_ready = 1'b1;
          check({tag, "_stall_hold"}, {held_ok, stall_bad}, 2'b10);
        end
      end else if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_out"}, out_data, e);
        end else begin
          check({tag, "_extra_out"}, outs, PIX - 1);
        end
        outs++;
        if (outs == t.stall_at) begin
          stall_left = 50;
          blk = outs % NCORES;
          out_ready = 1'b0;
        end
      end
      if (tile_done) begin
        tdn++;
        check({tag, "_tdone_pos"}, outs, PIX);
      end
      if (runs >= PIX) drain_cnt++;
      start = t.drain_start && (drain_cnt == 2);
    end
    start = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (tile_done) tdn++;
      if (busy) busy_after = 1;
    end
    check({tag, "_first_run"}, first_run, 0);
    check({tag, "_runs"}, runs, PIX);
    check({tag, "_outs"}, outs, t.exp_outs);
    check({tag, "_tile_done"}, tdn, t.exp_tdone);
    check({tag, "_busy_after"}, busy_after, 0);
  endtask

  initial begin
    int n_runs, tdn;
    bit busy_seen;
    tiles[0] = '{cr: 16'h0100, ci: 16'h0200, st: 16'h0013, ooo: 0, stall_at: -1,
                 drain_start: 0, exp_outs: PIX, exp_tdone: 1};
    tiles[1] = '{cr: 16'h0F00, ci: 16'h8100, st: 16'h0021, ooo: 1, stall_at: -1,
                 drain_start: 0, exp_outs: PIX, exp_tdone: 1};
    tiles[2] = '{cr: 16'h8400, ci: 16'h0010, st: 16'h7FFF, ooo: 0, stall_at: -1,
                 drain_start: 0, exp_outs: PIX, exp_tdone: 1};
    tiles[3] = '{cr: 16'h0123, ci: 16'h0456, st: 16'h0101, ooo: 1, stall_at: 5,
                 drain_start: 1, exp_outs: PIX, exp_tdone: 1};
    for (int i = 0; i < NCORES; i++) lat[i] = 10;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; cri = '0; cii = '0; cst = '0;
`ifdef MANDEL_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_core_run", core_run, 0);
    check("rst_core_c", |{core_cr, core_ci}, 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      run_tile(tiles[t], $sformatf("t%0d", t));
      if (t == 2) begin
        check("sign_wrap_x1", iss_r[1], 16'h83FF);
        check("sign_wrap_x2", iss_r[2], 16'h83FE);
        check("row1_real", iss_r[4], 16'h8400);
        check("row1_imag", iss_i[4], 16'h000F);
      end
    end

    // Reset in the middle of dispatch, then a fresh tile from pixel (0,0).
    @(negedge clk);
    cri = tiles[1].cr; cii = tiles[1].ci; cst = tiles[1].st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {busy, out_valid, tile_done, core_run}, 0);
    check("mid_rst_core_c", |{core_cr, core_ci}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_tile(tiles[0], "fresh");

`ifdef MANDEL_SCHED_ABORT_EN
    @(negedge clk);
    cri = tiles[0].cr; cii = tiles[0].ci; cst = tiles[0].st; start = 1'b1;
    n_runs = 0;
    for (int c = 0; c < 100 && n_runs < 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_runs += $countones(core_run);
    end
    check("abort_runs", n_runs, 8);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_idle", {busy, out_valid, core_run}, 0);
    tdn = 0; busy_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tile_done) tdn++;
      if (busy) busy_seen = 1;
    end
    check("abort_quiet", {tdn[7:0], 7'd0, busy_seen}, 0);
    run_tile(tiles[1], "post_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
